// File: rtl/svm_seq_dot_engine_if.sv
// Picker <-> SVM engine handshake bundle: weights/bias and sample in, pair decision and final winner out.
// The master side is the picker/host; the slave side is the dot-product engine.
interface svm_seq_dot_engine_if #(
   parameter int N_FEATURES   = 11,
   parameter int FEAT_WIDTH   = 4,
   parameter int WEIGHT_WIDTH = 8,
   parameter int BIAS_WIDTH   = 16
) ();
   logic                               start;
   logic [FEAT_WIDTH*N_FEATURES-1:0]   features;
   logic [WEIGHT_WIDTH*N_FEATURES-1:0] weight;
   logic [BIAS_WIDTH-1:0]              bia;
   logic                               picker_ready;
   logic [2:0]                         picker_winner;
   logic                               svmready;
   logic                               w_class;
   logic                               busy;
   logic                               done;
   logic [2:0]                         winner;
   logic                               err;

   modport master (
      output start, features, weight, bia, picker_ready, picker_winner,
      input  svmready, w_class, busy, done, winner, err
   );

   modport slave (
      input  start, features, weight, bia, picker_ready, picker_winner,
      output svmready, w_class, busy, done, winner, err
   );
endinterface

// File: rtl/svm_seq_dot_engine.sv
// Sequential one-vs-one SVM evaluator: one MAC per clock over the latched sample, bias scoring,
// and a per-pair decision pulse answered by the picker until it reports a final winner.
module svm_seq_dot_engine #(
   parameter int N_FEATURES   = 11,
   parameter int N_CLASSES    = 7,
   parameter int FEAT_WIDTH   = 4,
   parameter int WEIGHT_WIDTH = 8,
   parameter int BIAS_WIDTH   = 16
) (
   input logic                clk,
   input logic                rst,
   svm_seq_dot_engine_if.slave bus
);
   localparam int ACC_WIDTH   = WEIGHT_WIDTH + FEAT_WIDTH + 1 + $clog2(N_FEATURES);
   localparam int SCORE_WIDTH = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 1;
   localparam int PROD_WIDTH  = FEAT_WIDTH + 1 + WEIGHT_WIDTH;
   localparam int IDX_WIDTH   = $clog2(N_FEATURES);
   localparam int CNT_WIDTH   = $clog2(N_CLASSES);
   localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(N_FEATURES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N_CLASSES - 1);
   localparam logic signed [SCORE_WIDTH-1:0] SCORE_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_SCORE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                           state_q, state_d;
   logic signed [ACC_WIDTH-1:0]      acc_q, acc_d;
   logic [IDX_WIDTH-1:0]             idx_q, idx_d;
   logic [CNT_WIDTH-1:0]             cmp_cnt_q, cmp_cnt_d;
   logic [FEAT_WIDTH*N_FEATURES-1:0] feat_q, feat_d;
   logic                             svmready_q, svmready_d;
   logic                             w_class_q, w_class_d;
   logic                             busy_q, busy_d;
   logic                             done_q, done_d;
   logic [2:0]                       winner_q, winner_d;
   logic                             err_q, err_d;

   logic signed [FEAT_WIDTH:0]       feat_s;
   logic signed [WEIGHT_WIDTH-1:0]   weight_s;
   logic signed [PROD_WIDTH-1:0]     prod_s;
   logic signed [BIAS_WIDTH-1:0]     bia_s;
   logic signed [SCORE_WIDTH-1:0]    score_s;

   // Datapath: feature is zero-extended so it multiplies as a non-negative signed value.
   always_comb begin
      feat_s   = $signed({1'b0, feat_q[idx_q*FEAT_WIDTH +: FEAT_WIDTH]});
      weight_s = $signed(bus.weight[idx_q*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      prod_s   = PROD_WIDTH'(feat_s) * PROD_WIDTH'(weight_s);
      bia_s    = $signed(bus.bia);
      score_s  = SCORE_WIDTH'(acc_q) + SCORE_WIDTH'(bia_s);
   end

   // Next-state and output decode for the IDLE/MAC/SCORE/RESP sequence.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      cmp_cnt_d  = cmp_cnt_q;
      feat_d     = feat_q;
      svmready_d = 1'b0;
      w_class_d  = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      winner_d   = winner_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // a start landing on the done/err pulse cycle is deliberately dropped
            if (bus.start && !done_q && !err_q) begin
               feat_d    = bus.features;
               acc_d     = '0;
               idx_d     = '0;
               cmp_cnt_d = '0;
               busy_d    = 1'b1;
               state_d   = S_MAC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MAC: begin
            acc_d = acc_q + ACC_WIDTH'(prod_s);
            idx_d = idx_q + IDX_WIDTH'(1);
            if (idx_q == IDX_LAST) begin
               state_d = S_SCORE;
            end else begin
               state_d = S_MAC;
            end
         end
         S_SCORE: begin
            w_class_d  = (score_s >= SCORE_ZERO);
            svmready_d = 1'b1;
            cmp_cnt_d  = cmp_cnt_q + CNT_WIDTH'(1);
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (bus.picker_ready) begin
               winner_d = bus.picker_winner;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end else if (cmp_cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_MAC;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         idx_q      <= '0;
         cmp_cnt_q  <= '0;
         feat_q     <= '0;
         svmready_q <= 1'b0;
         w_class_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         winner_q   <= 3'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         cmp_cnt_q  <= cmp_cnt_d;
         feat_q     <= feat_d;
         svmready_q <= svmready_d;
         w_class_q  <= w_class_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         winner_q   <= winner_d;
         err_q      <= err_d;
      end
   end

   assign bus.svmready = svmready_q;
   assign bus.w_class  = w_class_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.winner   = winner_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_svm_seq_dot_engine.sv
// Directed + randomized bench for svm_seq_dot_engine; the bench itself plays the pair picker
// and predicts every decision from plain dot-product arithmetic.
module tb_svm_seq_dot_engine;
   localparam int NF = 11;
   localparam int NC = 7;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   int   feat_m [NF];
   int   wt_m   [NF];
   int   bias_m;
   int   pw     [NC][NC][NF];
   int   pb     [NC][NC];

   svm_seq_dot_engine_if bus ();

   svm_seq_dot_engine dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pack();
      for (int i = 0; i < NF; i++) begin
         bus.features[i*4 +: 4] = feat_m[i][3:0];
         bus.weight[i*8 +: 8]   = wt_m[i][7:0];
      end
      bus.bia = bias_m[15:0];
   endtask

   function automatic int model_score();
      int s;
      s = bias_m;
      for (int i = 0; i < NF; i++) s += feat_m[i] * wt_m[i];
      return s;
   endfunction

   function automatic int score_pair(input int a, input int b);
      int s;
      s = pb[a][b];
      for (int i = 0; i < NF; i++) s += feat_m[i] * pw[a][b][i];
      return s;
   endfunction

   task automatic load_pair(input int a, input int b);
      for (int i = 0; i < NF; i++) wt_m[i] = pw[a][b][i];
      bias_m = pb[a][b];
      pack();
   endtask

   task automatic start_inf();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // One decision; picker_ready is held high during MAC to show it is ignored there.
   task automatic run_single(input string tag, input int exp_w);
      int n;
      int sel;
      sel = int'($urandom_range(6, 0));
      pack();
      start_inf();
      cmp({tag, "_busy"}, bus.busy, 1);
      bus.picker_ready  = 1'b1;
      bus.picker_winner = 3'd7;
      n = 1;
      while (!bus.svmready && n < 40) begin
         tick();
         n++;
      end
      cmp({tag, "_lat"}, n, 13);
      cmp({tag, "_wcls"}, bus.w_class, exp_w);
      bus.picker_winner = sel[2:0];
      tick();
      bus.picker_ready = 1'b0;
      cmp({tag, "_done"}, bus.done, 1);
      cmp({tag, "_winner"}, bus.winner, sel);
      cmp({tag, "_svm_lo"}, bus.svmready, 0);
      cmp({tag, "_busy_lo"}, bus.busy, 0);
   endtask

   // Whole inference with an elimination picker (survivor vs. next class).
   task automatic run_full(input string tag, input bit respond, input int hold_winner);
      int n, a, b, cand, ewin;
      bit ew [6];
      cand = 0;
      for (int c = 1; c < NC; c++) begin
         ew[c-1] = (score_pair(cand, c) >= 0);
         if (ew[c-1]) cand = c;
      end
      ewin = respond ? cand : hold_winner;
      a = 0;
      b = 1;
      load_pair(a, b);
      start_inf();
      n = 1;
      for (int d = 0; d < NC - 1; d++) begin
         while (!bus.svmready && n < 13*(d+1) + 20) begin
            tick();
            n++;
         end
         cmp($sformatf("%s_lat%0d", tag, d), n, 13*(d+1));
         cmp($sformatf("%s_wcls%0d", tag, d), bus.w_class, ew[d]);
         if (bus.w_class) a = b;
         if (b >= NC - 1) begin
            if (respond) begin
               bus.picker_ready  = 1'b1;
               bus.picker_winner = a[2:0];
            end
         end else begin
            b++;
            load_pair(a, b);
         end
         tick();
         n++;
         bus.picker_ready = 1'b0;
      end
      cmp({tag, "_cyc"}, n, 79);
      cmp({tag, "_done"}, bus.done, respond);
      cmp({tag, "_err"}, bus.err, !respond);
      cmp({tag, "_busy"}, bus.busy, 0);
      cmp({tag, "_winner"}, bus.winner, ewin);
   endtask

   task automatic set_pattern1(input int bias);
      for (int i = 0; i < NF; i++) begin
         feat_m[i] = 0;
         wt_m[i]   = 0;
      end
      feat_m[0] = 3;
      wt_m[0]   = -2;
      bias_m    = bias;
   endtask

   task automatic set_uniform(input int f, input int w, input int bias);
      for (int i = 0; i < NF; i++) begin
         feat_m[i] = f;
         wt_m[i]   = w;
      end
      bias_m = bias;
   endtask

   task automatic randomize_tables(input bit force_pos);
      for (int i = 0; i < NF; i++) feat_m[i] = int'($urandom_range(15, 0));
      for (int a = 0; a < NC; a++)
         for (int b = 0; b < NC; b++) begin
            for (int i = 0; i < NF; i++) pw[a][b][i] = int'($urandom_range(255, 0)) - 128;
            pb[a][b] = force_pos ? 30000 : int'($urandom_range(8000, 0)) - 4000;
         end
   endtask

   task automatic check_all_zero(input string tag);
      cmp({tag, "_svmready"}, bus.svmready, 0);
      cmp({tag, "_w_class"}, bus.w_class, 0);
      cmp({tag, "_busy"}, bus.busy, 0);
      cmp({tag, "_done"}, bus.done, 0);
      cmp({tag, "_winner"}, bus.winner, 0);
      cmp({tag, "_err"}, bus.err, 0);
   endtask

   initial begin
      checks            = 0;
      failures          = 0;
      rst               = 1'b1;
      bus.start         = 1'b0;
      bus.features      = '0;
      bus.weight        = '0;
      bus.bia           = '0;
      bus.picker_ready  = 1'b0;
      bus.picker_winner = 3'd0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      set_pattern1(5);
      run_single("t1_neg1", 0);
      tick();
      set_pattern1(6);
      run_single("t2_zero", 1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cmp("start_on_done_ignored", bus.busy, 0);
      tick();

      set_uniform(15, -128, -32768);
      run_single("t4_min", 0);
      tick();
      set_uniform(15, 127, -32768);
      run_single("t4_max", 0);
      tick();
      set_uniform(15, -128, 21120);
      run_single("t4_min_zero", 1);
      tick();
      set_uniform(15, -128, 21119);
      run_single("t4_min_neg", 0);
      tick();
      set_uniform(15, 127, -20955);
      run_single("t4_max_zero", 1);
      tick();
      set_uniform(15, 127, -20956);
      run_single("t4_max_neg", 0);
      tick();

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NF; i++) begin
            feat_m[i] = int'($urandom_range(15, 0));
            wt_m[i]   = int'($urandom_range(255, 0)) - 128;
         end
         bias_m = int'($urandom_range(6000, 0)) - 3000;
         run_single($sformatf("rand%0d", r), (model_score() >= 0) ? 1 : 0);
         tick();
      end

      randomize_tables(1'b1);
      run_full("t3_full", 1'b1, 0);
      tick();
      run_full("t5_err", 1'b0, 6);
      bus.start = 1'b1;
      tick();
      cmp("start_on_err_ignored", bus.busy, 0);
      tick();
      bus.start = 1'b0;
      cmp("start_after_err", bus.busy, 1);
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("rst_mac");
      tick();

      set_pattern1(5);
      pack();
      start_inf();
      for (int k = 0; k < 40 && !bus.svmready; k++) tick();
      cmp("rst_resp_pre_svm", bus.svmready, 1);
      rst               = 1'b1;
      bus.picker_ready  = 1'b1;
      bus.picker_winner = 3'd5;
      tick();
      rst              = 1'b0;
      bus.picker_ready = 1'b0;
      check_all_zero("rst_resp");
      tick();
      run_single("t6_restart", 0);
      tick();

      for (int r = 0; r < 2; r++) begin
         randomize_tables(1'b0);
         run_full($sformatf("rfull%0d", r), 1'b1, 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
